c_readout_ctrl: RTL and testbench
=================================

# c_readout_ctrl

Read-side controller for the C (output) buffer. Accepts CFU read commands from the CPU, fetches a 128-bit C row from the buffer's synchronous read port, and returns one selected 32-bit lane over a valid/ready response channel. It sits between the CFU command decoder and the C buffer, opposite the write-side controller that fills C from the systolic array. It keeps a one-row cache so consecutive lane reads of the same row skip the SRAM, and it guards against read-after-write hazards with the writer.

## Interface

Parameters:
- ADDR_W, 16, C buffer row-address width.
- ROW_W, 128, C row width. Fixed at 4 lanes × 32 bits.

Ports:
- Reset is `rst_n`, synchronous, active-low. The clock is `clk`.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  command accepted this cycle.
- funct  in  3  command opcode.
- input0  in  32  row index; the low ADDR_W bits are used.
- input1  in  32  lane select; bits [1:0] are used.
- c_rd_en  out  1  C buffer read enable.
- c_rd_addr  out  ADDR_W  C buffer read address.
- c_rd_data  in  ROW_W  C buffer read data, valid 1 cycle after c_rd_en.
- c_wr_en  in  1  writer's C buffer write strobe (snooped).
- c_wr_addr  in  ADDR_W  writer's C buffer write address (snooped).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts response.
- rsp_data  out  32  selected lane.

## Operation

- Opcodes:
  - FUNCT_READ_C = 3'd3: read a lane of a C row.
  - FUNCT_CLEAR = 3'd1: invalidate the cache. It produces no response from this block.
  - All other opcodes are ignored and not acknowledged here.
- cmd_ready = (state == IDLE). A command is taken when cmd_valid && cmd_ready && funct ∈ {1, 3}.
- Lane mapping: lane k = row bits [32k+31 : 32k]. Lane 0 is the LSBs.
- FSM states: IDLE, RD_REQ, RD_WAIT, RESP.
- IDLE, READ_C accepted: latch addr = input0[ADDR_W-1:0] and lane = input1[1:0].
  - Cache hit (cache_valid && tag == addr): load rsp_data from the cached row and go to RESP.
  - Miss: go to RD_REQ.
- IDLE, CLEAR accepted: cache_valid <= 0. Stay in IDLE.
- RD_REQ:
  - If c_wr_en && c_wr_addr == addr, hold in RD_REQ with c_rd_en = 0 (hazard stall).
  - Otherwise assert c_rd_en with c_rd_addr = addr and go to RD_WAIT.
- RD_WAIT: capture c_rd_data into the cache (tag <= addr, cache_valid <= 1) and set rsp_data to the selected lane. Go to RESP.
  - Exception: if c_wr_en && c_wr_addr == addr in this cycle, still respond with the captured data but leave cache_valid = 0.
- RESP: rsp_valid = 1, and rsp_data stays stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Snoop: in any state, c_wr_en && c_wr_addr == tag clears cache_valid. If this coincides with a RD_WAIT fill, the clear wins.
- Reset (rst_n = 0, sampled at clk), from any state:
  - state goes to IDLE and cache_valid to 0.
  - rsp_valid, c_rd_en, rsp_data, c_rd_addr and tag go to 0.
  - Any in-flight SRAM data is discarded.

## Timing

- Reset values:
  - cmd_ready = 1 (IDLE).
  - rsp_valid = 0.
  - rsp_data = 0.
  - c_rd_en = 0.
  - c_rd_addr = 0.
- Miss latency, with T the accept cycle:
  - T+1: c_rd_en = 1.
  - T+2: data is captured.
  - T+3: rsp_valid = 1.
  - Each hazard-stall cycle adds 1.
- Hit latency: rsp_valid = 1 at T+1.
- Back-to-back: the next command can be accepted in the cycle after the response handshake. There is no overlap of commands.
- c_rd_en is a single-cycle pulse. c_rd_addr is registered and holds its last value otherwise.
- Backpressure: with rsp_ready = 0 held N cycles, rsp_valid stays 1 and rsp_data is unchanged. cmd_ready stays 0 throughout.

## Structure

- Shared package `c_buf_pkg` holds:
  - FUNCT_CLEAR and FUNCT_READ_C.
  - LANE_W = 32 and LANES = 4.
  - The state enum {IDLE, RD_REQ, RD_WAIT, RESP}.
  - The default ADDR_W, so the write-side controller and this block agree.
- One sub-module, `c_row_cache`, holds tag, valid, and the ROW_W data register. It has fill, invalidate (clear or snoop) and lookup-hit outputs.
- The FSM and lane mux live in the top.

## Test plan

- Row 5 preloaded with 0x44444444_33333333_22222222_11111111. READ_C(5, lane 2) → c_rd_en at T+1 with addr 5; rsp_valid at T+3 with rsp_data 0x33333333.
- Immediately READ_C(5, lane 0) → no c_rd_en; rsp_valid at T+1 with rsp_data 0x11111111.
- Writer pulses c_wr_en with c_wr_addr 5, then READ_C(5, lane 3) → miss path; c_rd_en is issued and the new SRAM value is returned.
- c_wr_en with c_wr_addr 7 held for 3 cycles while RD_REQ targets 7 → c_rd_en is delayed exactly 3 cycles; the response follows 2 cycles after c_rd_en.
- rsp_ready held low for 4 cycles → rsp_valid and rsp_data are stable and cmd_ready = 0. CLEAR, then READ_C of the same row → miss path.
- rst_n low during RD_WAIT → the next cycle shows IDLE with rsp_valid = 0 and cmd_ready = 1. A following read of that row takes the miss path.

Source files
------------

// File: rtl/c_buf_pkg.sv
// Shared C-buffer definitions used by both the read-side and write-side controllers.
package c_buf_pkg;

  localparam int C_ADDR_W = 16;
  localparam int LANE_W   = 32;
  localparam int LANES    = 4;
  localparam int C_ROW_W  = LANE_W * LANES;

  localparam logic [2:0] FUNCT_CLEAR  = 3'd1;
  localparam logic [2:0] FUNCT_READ_C = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } rd_state_e;

  // Lane 0 sits in the least significant bits of the row.
  function automatic logic [LANE_W-1:0] lane_sel(input logic [C_ROW_W-1:0] row,
                                                 input logic [1:0]         lane);
    logic [LANE_W-1:0] r;
    case (lane)
      2'd0:    r = row[31:0];
      2'd1:    r = row[63:32];
      2'd2:    r = row[95:64];
      default: r = row[127:96];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/c_readout_ctrl_if.sv
// CPU-side command/response channel of the C readout controller.
interface c_readout_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  funct;
  logic [31:0] input0;
  logic [31:0] input1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, funct, input0, input1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, funct, input0, input1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/c_row_cache.sv
// One-row cache of the C buffer: tag, valid and row data, with fill, invalidate and lookup.
// Invalidation (clear or a snooped write to the cached tag) takes priority over a fill.
module c_row_cache
  import c_buf_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int ROW_W  = C_ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_i,
  input  logic              fill_ok_i,
  input  logic [ADDR_W-1:0] fill_tag_i,
  input  logic [ROW_W-1:0]  fill_row_i,
  input  logic              clear_i,
  input  logic              snoop_en_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [ROW_W-1:0]  row_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q;
  logic [ROW_W-1:0]  row_q;
  logic              inval;

  assign inval = clear_i || (snoop_en_i && (snoop_addr_i == tag_q));

  always_comb begin
    valid_d = valid_q;
    if (fill_i) valid_d = fill_ok_i;
    if (inval)  valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (fill_i) begin
        tag_q <= fill_tag_i;
        row_q <= fill_row_i;
      end
    end
  end

  assign hit_o = valid_q && (tag_q == lookup_addr_i);
  assign row_o = row_q;

endmodule

// File: rtl/c_readout_ctrl.sv
// Read-side C buffer controller: serves READ_C lane reads from a one-row cache or the SRAM,
// stalls on writer hazards, and holds the response until the CPU accepts it.
module c_readout_ctrl
  import c_buf_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int ROW_W  = C_ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  c_readout_ctrl_if.slave   cpu,
  output logic              c_rd_en,
  output logic [ADDR_W-1:0] c_rd_addr,
  input  logic [ROW_W-1:0]  c_rd_data,
  input  logic              c_wr_en,
  input  logic [ADDR_W-1:0] c_wr_addr
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [LANE_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_lane;
  logic              accept_rd, accept_clr;
  logic              wr_hazard;
  logic              cache_hit;
  logic [ROW_W-1:0]  cache_row;
  logic              fill, clear;
  logic              unused_cmd_bits;

  assign cmd_addr        = cpu.input0[ADDR_W-1:0];
  assign cmd_lane        = cpu.input1[1:0];
  assign unused_cmd_bits = ^{cpu.input0[31:ADDR_W], cpu.input1[31:2]};

  assign accept_rd  = cpu.cmd_valid && (state_q == IDLE) && (cpu.funct == FUNCT_READ_C);
  assign accept_clr = cpu.cmd_valid && (state_q == IDLE) && (cpu.funct == FUNCT_CLEAR);
  assign wr_hazard  = c_wr_en && (c_wr_addr == addr_q);

  c_row_cache #(
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_cache (
    .clk           (clk),
    .rst_n         (rst_n),
    .fill_i        (fill),
    .fill_ok_i     (!wr_hazard),
    .fill_tag_i    (addr_q),
    .fill_row_i    (c_rd_data),
    .clear_i       (clear),
    .snoop_en_i    (c_wr_en),
    .snoop_addr_i  (c_wr_addr),
    .lookup_addr_i (cmd_addr),
    .hit_o         (cache_hit),
    .row_o         (cache_row)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    rsp_data_d = rsp_data_q;
    rd_addr_d  = rd_addr_q;
    fill       = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_rd) begin
          addr_d = cmd_addr;
          lane_d = cmd_lane;
          if (cache_hit) begin
            rsp_data_d = lane_sel(cache_row, cmd_lane);
            state_d    = RESP;
          end else begin
            rd_addr_d = cmd_addr;
            state_d   = RD_REQ;
          end
        end else if (accept_clr) begin
          clear = 1'b1;
        end
      end
      RD_REQ: begin
        if (!wr_hazard) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Fill is disqualified inside the cache when the writer hits this row now.
        fill       = 1'b1;
        rsp_data_d = lane_sel(c_rd_data, lane_q);
        state_d    = RESP;
      end
      RESP: begin
        if (cpu.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lane_q     <= '0;
      rsp_data_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      rsp_data_q <= rsp_data_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign c_rd_en       = (state_q == RD_REQ) && !wr_hazard;
  assign c_rd_addr     = rd_addr_q;
  assign cpu.cmd_ready = (state_q == IDLE);
  assign cpu.rsp_valid = (state_q == RESP);
  assign cpu.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_c_readout_ctrl.sv
// Directed bench for c_readout_ctrl with a behavioural synchronous C buffer.
module tb_c_readout_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         c_rd_en;
  logic [15:0]  c_rd_addr;
  logic [127:0] c_rd_data;
  logic         c_wr_en;
  logic [15:0]  c_wr_addr;
  logic [127:0] wr_data;
  logic         pre_en;
  logic [3:0]   pre_addr;
  logic [127:0] pre_data;
  logic [127:0] mem [16];

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] ROW5 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] ROW6 = 128'h66660003_66660002_66660001_66660000;
  localparam logic [127:0] ROW7 = 128'h77770003_77770002_77770001_77770000;
  localparam logic [127:0] NEW5 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] NEW7 = 128'hABCD0003_ABCD0002_ABCD0001_ABCD0000;

  c_readout_ctrl_if bus ();

  c_readout_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus),
    .c_rd_en   (c_rd_en),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data),
    .c_wr_en   (c_wr_en),
    .c_wr_addr (c_wr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en)  mem[pre_addr] <= pre_data;
    if (c_wr_en) mem[c_wr_addr[3:0]] <= wr_data;
    if (c_rd_en) c_rd_data <= mem[c_rd_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exp_rd / exp_rsp are cycle offsets from the accept cycle T; exp_rd = 0 means no SRAM read.
  task automatic do_read(input logic [15:0] a, input logic [1:0] ln, input logic [31:0] exp,
                         input int exp_rd, input int exp_rsp, input int hold);
    int rd_at = 0;
    int rd_cnt = 0;
    int rsp_at = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.funct     = 3'd3;
    bus.input0    = {16'hA5A5, a};
    bus.input1    = {30'h1234567, ln};
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (c_rd_en) begin
        rd_cnt++;
        if (rd_at == 0) rd_at = n;
        chk("rd_addr", c_rd_addr, a);
      end
      if (bus.rsp_valid) begin
        rsp_at = n;
        break;
      end
    end
    chk("rd_cycle", rd_at, exp_rd);
    chk("rd_pulses", rd_cnt, (exp_rd != 0) ? 1 : 0);
    chk("rsp_cycle", rsp_at, exp_rsp);
    chk("rsp_data", bus.rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_data", bus.rsp_data, exp);
      chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", bus.rsp_valid, 1'b0);
    chk("post_cmd_ready", bus.cmd_ready, 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] f);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.funct     = f;
    bus.input0    = 32'd5;
    bus.input1    = 32'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nocmd_valid", bus.rsp_valid, 1'b0);
      chk("nocmd_rd_en", c_rd_en, 1'b0);
      chk("nocmd_ready", bus.cmd_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.funct     = 3'd0;
    bus.input0    = 32'd0;
    bus.input1    = 32'd0;
    bus.rsp_ready = 1'b1;
    c_wr_en       = 1'b0;
    c_wr_addr     = 16'd0;
    wr_data       = '0;
    pre_en        = 1'b0;
    pre_addr      = 4'd0;
    pre_data      = '0;

    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = 4'd5; pre_data = ROW5;
    @(posedge clk); #1;
    pre_addr = 4'd6; pre_data = ROW6;
    @(posedge clk); #1;
    pre_addr = 4'd7; pre_data = ROW7;
    @(posedge clk); #1;
    pre_en = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rd_en", c_rd_en, 1'b0);
    chk("rst_rd_addr", c_rd_addr, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Miss, then a hit on the same row.
    do_read(16'd5, 2'd2, 32'h33333333, 1, 3, 0);
    do_read(16'd5, 2'd0, 32'h11111111, 0, 1, 0);

    // Writer updates row 5; the snoop must force a refetch.
    @(posedge clk); #1;
    c_wr_en = 1'b1; c_wr_addr = 16'd5; wr_data = NEW5;
    @(posedge clk); #1;
    c_wr_en = 1'b0;
    do_read(16'd5, 2'd3, 32'hDDDD0003, 1, 3, 0);

    // Writer hits row 7 for three cycles while the read waits in RD_REQ.
    fork
      do_read(16'd7, 2'd1, 32'hABCD0001, 4, 6, 0);
      begin
        @(posedge clk);
        @(posedge clk); #1;
        c_wr_en = 1'b1; c_wr_addr = 16'd7; wr_data = NEW7;
        repeat (3) @(posedge clk);
        #1 c_wr_en = 1'b0;
      end
    join

    // Backpressure on a cache hit, then CLEAR forces a miss.
    bus.rsp_ready = 1'b0;
    do_read(16'd7, 2'd2, 32'hABCD0002, 0, 1, 4);
    send_cmd(3'd1);
    do_read(16'd7, 2'd0, 32'hABCD0000, 1, 3, 0);

    // Unsupported opcode does nothing.
    send_cmd(3'd2);

    // Reset lands while a row 6 read sits in RD_WAIT.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.funct = 3'd3; bus.input0 = 32'd6; bus.input1 = 32'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rstw_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rstw_rsp_data", bus.rsp_data, 32'd0);
    chk("rstw_rd_addr", c_rd_addr, 16'd0);
    @(negedge clk);
    chk("rstw_no_late_valid", bus.rsp_valid, 1'b0);
    do_read(16'd7, 2'd3, 32'hABCD0003, 1, 3, 0);
    do_read(16'd6, 2'd0, 32'h66660000, 1, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
